cmp_stat_unit: RTL

Result-statistics stage directly downstream of the 4-bit magnitude comparator. It consumes the comparator's 8-bit one-hot result code over a valid/ready handshake and classifies each code as less, equal, greater or illegal. It keeps saturating per-class counters, tracks runs of identical results and flags a streak when a run reaches a threshold. Totals are read out through a snapshot handshake that freezes intake until acknowledged.

---
 rtl/cmp_stat_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cmp_stat_unit.sv
// Result statistics for the 4-bit magnitude comparator: per-class saturating counts,
// run-length/streak tracking and a snapshot handshake that freezes intake.
module cmp_stat_unit #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RUN_W      = 4,
    parameter int unsigned RUN_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       cmp_y,
    input  logic             clear,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_err,
    output logic [1:0]       last_cls,
    output logic [RUN_W-1:0] run_len,
    output logic             streak
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StFrozen = 2'd2;

    localparam logic [1:0] ClsNone = 2'd0;
    localparam logic [1:0] ClsLt   = 2'd1;
    localparam logic [1:0] ClsEq   = 2'd2;
    localparam logic [1:0] ClsGt   = 2'd3;

    localparam logic [RUN_W-1:0] RunThresh = RUN_W'(RUN_THRESH);
    localparam logic [RUN_W-1:0] RunMax    = {RUN_W{1'b1}};
    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_lt_q, cnt_lt_d, cnt_eq_q, cnt_eq_d;
    logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d, cnt_err_q, cnt_err_d;
    logic [1:0]       last_cls_q, last_cls_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             streak_q, streak_d;
    logic             snap_valid_q, snap_valid_d;
    logic             accept;
    logic             legal;
    logic [1:0]       cls;

    assign in_ready = (state_q != StFrozen);
    assign accept   = in_valid & in_ready;

    always_comb begin
        legal = 1'b1;
        cls   = ClsNone;
        case (cmp_y)
            8'h01:   cls = ClsLt;
            8'h02:   cls = ClsEq;
            8'h04:   cls = ClsGt;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_lt_d   = cnt_lt_q;
        cnt_eq_d   = cnt_eq_q;
        cnt_gt_d   = cnt_gt_q;
        cnt_err_d  = cnt_err_q;
        last_cls_d = last_cls_q;
        run_len_d  = run_len_q;
        streak_d   = 1'b0;

        if (clear || (state_q == StFrozen && snap_ack)) begin
            state_d    = StIdle;
            cnt_lt_d   = '0;
            cnt_eq_d   = '0;
            cnt_gt_d   = '0;
            cnt_err_d  = '0;
            last_cls_d = ClsNone;
            run_len_d  = '0;
        end else if (state_q != StFrozen) begin
            if (accept) begin
                state_d = StRun;
                if (legal) begin
                    unique case (cls)
                        ClsLt: if (cnt_lt_q != CntMax) cnt_lt_d = cnt_lt_q + CNT_W'(1);
                        ClsEq: if (cnt_eq_q != CntMax) cnt_eq_d = cnt_eq_q + CNT_W'(1);
                        ClsGt: if (cnt_gt_q != CntMax) cnt_gt_d = cnt_gt_q + CNT_W'(1);
                        default: ;
                    endcase
                    if (cls == last_cls_q) begin
                        if (run_len_q != RunMax) run_len_d = run_len_q + RUN_W'(1);
                    end else begin
                        run_len_d  = RUN_W'(1);
                        last_cls_d = cls;
                    end
                    // Fire only on the step into the threshold, never while saturated.
                    streak_d = (run_len_d == RunThresh) &&
                               ((run_len_d != run_len_q) || (cls != last_cls_q));
                end else begin
                    if (cnt_err_q != CntMax) cnt_err_d = cnt_err_q + CNT_W'(1);
                    run_len_d  = '0;
                    last_cls_d = ClsNone;
                end
            end
            if (snap_req) state_d = StFrozen;
        end

        snap_valid_d = (state_d == StFrozen);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_lt_q     <= '0;
            cnt_eq_q     <= '0;
            cnt_gt_q     <= '0;
            cnt_err_q    <= '0;
            last_cls_q   <= ClsNone;
            run_len_q    <= '0;
            streak_q     <= 1'b0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_lt_q     <= cnt_lt_d;
            cnt_eq_q     <= cnt_eq_d;
            cnt_gt_q     <= cnt_gt_d;
            cnt_err_q    <= cnt_err_d;
            last_cls_q   <= last_cls_d;
            run_len_q    <= run_len_d;
            streak_q     <= streak_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign cnt_lt     = cnt_lt_q;
    assign cnt_eq     = cnt_eq_q;
    assign cnt_gt     = cnt_gt_q;
    assign cnt_err    = cnt_err_q;
    assign last_cls   = last_cls_q;
    assign run_len    = run_len_q;
    assign streak     = streak_q;
    assign snap_valid = snap_valid_q;

endmodule
